// File: rtl/core_out_uart_tx.sv
// Byte FIFO plus 8N1 serialiser for the core's character-output port.
// The core cannot be stalled, so excess bytes are dropped and flagged.
module core_out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               out_en,
    input  logic [7:0]         out_data,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNTW  = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0]      CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [CNTW-1:0]    FULL    = CNTW'(DEPTH);
    localparam logic [CNTW-1:0]    OCC_ONE = CNTW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          sh_q, sh_d;
    logic                tx_q, tx_d;
    logic                ovf_q, ovf_d;
    logic [FIFO_AW-1:0]  wptr_q, wptr_d;
    logic [FIFO_AW-1:0]  rptr_q, rptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [7:0]          mem_q [DEPTH];

    logic pop;
    logic push;
    logic last;
    logic full;

    assign last = (cnt_q == CNT_MAX);
    assign full = (count_q == FULL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = last ? '0 : cnt_q + CNT_ONE;
                if (last) begin
                    tx_d    = sh_q[0];
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = last ? '0 : cnt_q + CNT_ONE;
                if (last) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        sh_d  = {1'b0, sh_q[7:1]};
                        idx_d = idx_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            STOP: begin
                cnt_d = last ? '0 : cnt_q + CNT_ONE;
                if (last) begin
                    // Chain straight into the next frame with no idle gap.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop on the same edge frees the slot that a push into a full FIFO needs.
    always_comb begin
        push    = out_en && (!full || pop);
        ovf_d   = ovf_q || (out_en && !push);
        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= out_data;
        end
    end

    assign tx         = tx_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_core_out_uart_tx.sv
// Directed bench for core_out_uart_tx at 4 clocks per bit, 16-deep FIFO.
// Expected line levels come from an independent per-cycle frame model.
module tb_core_out_uart_tx;

    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int FRM = 10 * CPB;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          out_en = 1'b0;
    logic [7:0]    out_data = 8'd0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifo_count;

    int nv = 0;
    int nerr = 0;

    logic [7:0]  pat [64];
    logic [7:0]  expb [64];
    logic [AW:0] cnt_log [1024];
    logic        ovf_log [1024];

    core_out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(AW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .out_en(out_en),
        .out_data(out_data),
        .tx(tx),
        .busy(busy),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        out_en  = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // Pushes pat[0..n-1] on edges E0..E(n-1), plus xd on edge E(xk).
    // Checks tx after every edge of nexp back-to-back frames from E1.
    task automatic run_stream(input int n, input int xk,
                              input logic [7:0] xd, input int nexp,
                              input string nm);
        int lastk;
        int t;
        int bi;
        int busy_cnt;
        logic [7:0] b;
        logic e;
        lastk = nexp * FRM + 1;
        busy_cnt = 0;
        for (int k = 0; k <= lastk; k++) begin
            out_en   = 1'b0;
            out_data = 8'd0;
            if (k < n) begin
                out_en   = 1'b1;
                out_data = pat[k];
            end
            if (k == xk) begin
                out_en   = 1'b1;
                out_data = xd;
            end
            tick();
            out_en = 1'b0;
            cnt_log[k] = fifo_count;
            ovf_log[k] = overflow;
            if (k >= 1 && busy === 1'b1) busy_cnt++;
            if (k >= 1 && k <= nexp * FRM) begin
                t  = k - 1;
                b  = expb[t / FRM];
                bi = t % FRM;
                if (bi < CPB) e = 1'b0;
                else if (bi < 9 * CPB) e = b[(bi - CPB) / CPB];
                else e = 1'b1;
                nv++;
                if (tx !== e) begin
                    nerr++;
                    $display("FAIL %s tx frame %0d slot %0d: got %b want %b",
                             nm, t / FRM, bi, tx, e);
                end
            end
        end
        nv++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            nerr++;
            $display("FAIL %s idle_end: busy=%b tx=%b want busy=0 tx=1",
                     nm, busy, tx);
        end
        nv++;
        if (busy_cnt != nexp * FRM) begin
            nerr++;
            $display("FAIL %s busy_time: got %0d want %0d",
                     nm, busy_cnt, nexp * FRM);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        nv++;
        if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 ||
            fifo_count !== 5'd0) begin
            nerr++;
            $display("FAIL reset_state: tx=%b busy=%b ovf=%b cnt=%0d want 1 0 0 0",
                     tx, busy, overflow, fifo_count);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        pat[0]  = 8'h48;
        expb[0] = 8'h48;
        run_stream(1, -1, 8'h00, 1, "single");
        nv++;
        if (cnt_log[0] !== 5'd1 || cnt_log[1] !== 5'd0) begin
            nerr++;
            $display("FAIL single_count: E0=%0d E1=%0d want 1 0",
                     cnt_log[0], cnt_log[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pat[0]  = 8'h55;
        pat[1]  = 8'hAA;
        expb[0] = 8'h55;
        expb[1] = 8'hAA;
        run_stream(2, -1, 8'h00, 2, "b2b");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 18; i++) pat[i] = 8'(i);
        for (int i = 0; i < 17; i++) expb[i] = 8'(i);
        run_stream(18, -1, 8'h00, 17, "ovf");
        nv++;
        if (cnt_log[1] !== 5'd1 || cnt_log[16] !== 5'd16 ||
            cnt_log[17] !== 5'd16) begin
            nerr++;
            $display("FAIL ovf_count: E1=%0d E16=%0d E17=%0d want 1 16 16",
                     cnt_log[1], cnt_log[16], cnt_log[17]);
        end
        nv++;
        if (ovf_log[16] !== 1'b0 || ovf_log[17] !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_set: E16=%b E17=%b want 0 1",
                     ovf_log[16], ovf_log[17]);
        end
        nv++;
        if (overflow !== 1'b1 || fifo_count !== 5'd0) begin
            nerr++;
            $display("FAIL ovf_sticky: ovf=%b cnt=%0d want 1 0",
                     overflow, fifo_count);
        end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pat[i]  = 8'(8'h80 + i);
            expb[i] = 8'(8'h80 + i);
        end
        expb[17] = 8'hC3;
        run_stream(17, FRM + 1, 8'hC3, 18, "fullpp");
        nv++;
        if (cnt_log[FRM] !== 5'd16 || cnt_log[FRM + 1] !== 5'd16) begin
            nerr++;
            $display("FAIL fullpp_count: pre=%0d post=%0d want 16 16",
                     cnt_log[FRM], cnt_log[FRM + 1]);
        end
        nv++;
        if (ovf_log[FRM + 1] !== 1'b0 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL fullpp_ovf: edge=%b end=%b want 0 0",
                     ovf_log[FRM + 1], overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d [3];
        int bad;
        d[0] = 8'hA5;
        d[1] = 8'h3C;
        d[2] = 8'h0F;
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            out_en   = (k < 3);
            out_data = (k < 3) ? d[k] : 8'h00;
            tick();
        end
        out_en = 1'b0;
        nv++;
        if (tx !== 1'b0 || fifo_count !== 5'd2 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_pre: tx=%b cnt=%0d busy=%b want 0 2 1",
                     tx, fifo_count, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nv++;
        if (tx !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_async: tx=%b cnt=%0d busy=%b want 1 0 0",
                     tx, fifo_count, busy);
        end
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        nv++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL rst_mid_after: %0d cycles not idle want 0", bad);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 5; i++) begin
                pat[i]  = 8'((g * 5 + i) * 37 + 11);
                expb[i] = 8'((g * 5 + i) * 37 + 11);
            end
            run_stream(5, -1, 8'h00, 5, $sformatf("wrap%0d", g));
        end
        nv++;
        if (overflow !== 1'b0 || fifo_count !== 5'd0) begin
            nerr++;
            $display("FAIL wrap_end: ovf=%b cnt=%0d want 0 0",
                     overflow, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_frame();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
